// File: rtl/spi_bus_arbiter.sv
// +--------------------------------------------------------------------------+
// | spi_bus_arbiter: shares one SPI bus between fetch and load/store ports.   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module spi_bus_arbiter #(
    parameter int SCLK_HALF = 1,
    parameter int ADDR_W    = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_done,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic              ls_sel,
    input  logic [1:0]        ls_size,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic [31:0]       ls_rdata,
    output logic              ls_done,
    output logic              spi_sclk,
    output logic              spi_mosi,
    input  logic              spi_miso,
    output logic              spi_cs1_n,
    output logic              spi_cs2_n,
    output logic              busy
);

    localparam int HDR_BITS = 8 + ADDR_W;
    localparam int FRAME_W  = HDR_BITS + 32;
    localparam int CNT_W    = $clog2(FRAME_W + 1);
    localparam int DIV_W    = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SELECT = 2'd1;
    localparam logic [1:0] S_SHIFT  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]         state_q, state_d;
    logic               gnt_ls_q, gnt_ls_d;
    logic               last_ls_q, last_ls_d;
    logic               sel_q, sel_d;
    logic               we_q, we_d;
    logic [1:0]         nb_q, nb_d;
    logic [FRAME_W-1:0] tx_q, tx_d;
    logic [31:0]        rx_q, rx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               phase_q, phase_d;
    logic [31:0]        if_rdata_q, if_rdata_d;
    logic [31:0]        ls_rdata_q, ls_rdata_d;
    logic               sclk_q, sclk_d;
    logic               mosi_q, mosi_d;
    logic               cs1_n_q, cs1_n_d;
    logic               cs2_n_q, cs2_n_d;

    logic               w_pick_ls;
    logic [7:0]         w_cmd;
    logic [ADDR_W-1:0]  w_addr;
    logic [31:0]        w_data;
    logic               w_div_end;
    logic               w_active_d;

    // Received bytes arrive byte0-first; nb: 0=1 byte, 1=2 bytes, 2=4 bytes.
    function automatic logic [31:0] bswap(input logic [31:0] r, input logic [1:0] nb);
        case (nb)
            2'd0:    bswap = {24'd0, r[7:0]};
            2'd1:    bswap = {16'd0, r[7:0], r[15:8]};
            default: bswap = {r[7:0], r[15:8], r[23:16], r[31:24]};
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] frame_bits(input logic [1:0] nb);
        case (nb)
            2'd0:    frame_bits = CNT_W'(HDR_BITS + 8);
            2'd1:    frame_bits = CNT_W'(HDR_BITS + 16);
            default: frame_bits = CNT_W'(HDR_BITS + 32);
        endcase
    endfunction

    assign w_div_end = (div_q == DIV_W'(SCLK_HALF - 1));

    always_comb begin
        state_d    = state_q;
        gnt_ls_d   = gnt_ls_q;
        last_ls_d  = last_ls_q;
        sel_d      = sel_q;
        we_d       = we_q;
        nb_d       = nb_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        phase_d    = phase_q;
        if_rdata_d = if_rdata_q;
        ls_rdata_d = ls_rdata_q;
        w_pick_ls  = 1'b0;
        w_cmd      = 8'h03;
        w_addr     = if_addr;
        w_data     = 32'd0;

        case (state_q)
            S_IDLE: begin
                if (if_req || ls_req) begin
                    // Tie goes to whoever was not granted last.
                    w_pick_ls = ls_req && (!if_req || !last_ls_q);
                    gnt_ls_d  = w_pick_ls;
                    last_ls_d = w_pick_ls;
                    sel_d     = w_pick_ls && ls_sel;
                    we_d      = w_pick_ls && ls_we;
                    nb_d      = !w_pick_ls ? 2'd2 : (ls_size[1] ? 2'd2 : (ls_size[0] ? 2'd1 : 2'd0));
                    w_cmd     = we_d ? 8'h02 : 8'h03;
                    w_addr    = w_pick_ls ? ls_addr : if_addr;
                    w_data    = we_d ? {ls_wdata[7:0], ls_wdata[15:8], ls_wdata[23:16], ls_wdata[31:24]} : 32'd0;
                    tx_d      = {w_cmd, w_addr, w_data};
                    cnt_d     = frame_bits(nb_d);
                    div_d     = '0;
                    phase_d   = 1'b0;
                    state_d   = S_SELECT;
                end
            end
            S_SELECT: begin
                if (w_div_end) begin
                    div_d   = '0;
                    phase_d = 1'b0;
                    rx_d    = {rx_q[30:0], spi_miso};
                    state_d = S_SHIFT;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_SHIFT: begin
                if (w_div_end) begin
                    div_d = '0;
                    if (!phase_q) begin
                        phase_d = 1'b1;
                        tx_d    = {tx_q[FRAME_W-2:0], 1'b0};
                        cnt_d   = cnt_q - 1'b1;
                    end else if (cnt_q == '0) begin
                        state_d = S_DONE;
                        if (!gnt_ls_q) begin
                            if_rdata_d = bswap(rx_q, 2'd2);
                        end else if (!we_q) begin
                            ls_rdata_d = bswap(rx_q, nb_q);
                        end
                    end else begin
                        phase_d = 1'b0;
                        rx_d    = {rx_q[30:0], spi_miso};
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Pad outputs are registered from next-state so they never glitch.
        w_active_d = (state_d == S_SELECT) || (state_d == S_SHIFT);
        sclk_d     = (state_d == S_SHIFT) && !phase_d;
        mosi_d     = w_active_d && tx_d[FRAME_W-1];
        cs1_n_d    = !(w_active_d && !sel_d);
        cs2_n_d    = !(w_active_d && sel_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            gnt_ls_q   <= 1'b0;
            last_ls_q  <= 1'b0;
            sel_q      <= 1'b0;
            we_q       <= 1'b0;
            nb_q       <= 2'd0;
            tx_q       <= '0;
            rx_q       <= '0;
            cnt_q      <= '0;
            div_q      <= '0;
            phase_q    <= 1'b0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            cs1_n_q    <= 1'b1;
            cs2_n_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            gnt_ls_q   <= gnt_ls_d;
            last_ls_q  <= last_ls_d;
            sel_q      <= sel_d;
            we_q       <= we_d;
            nb_q       <= nb_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            phase_q    <= phase_d;
            if_rdata_q <= if_rdata_d;
            ls_rdata_q <= ls_rdata_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            cs1_n_q    <= cs1_n_d;
            cs2_n_q    <= cs2_n_d;
        end
    end

    assign if_rdata  = if_rdata_q;
    assign ls_rdata  = ls_rdata_q;
    assign if_done   = (state_q == S_DONE) && !gnt_ls_q;
    assign ls_done   = (state_q == S_DONE) && gnt_ls_q;
    assign busy      = (state_q != S_IDLE);
    assign spi_sclk  = sclk_q;
    assign spi_mosi  = mosi_q;
    assign spi_cs1_n = cs1_n_q;
    assign spi_cs2_n = cs2_n_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_bus_arbiter.sv
// +--------------------------------------------------------------------------+
// | tb_spi_bus_arbiter: scoreboard bench with SPI slave models.              |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_spi_bus_arbiter;

    typedef struct {
        logic        is_ls;
        logic [63:0] frame;
        int          nbits;
        int          lat;
        logic        cs2;
        logic [31:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, ls_req, ls_we, ls_sel;
    logic [1:0]  ls_size;
    logic [23:0] if_addr, ls_addr;
    logic [31:0] ls_wdata, if_rdata, ls_rdata;
    logic        if_done, ls_done, spi_sclk, spi_mosi, spi_miso, spi_cs1_n, spi_cs2_n, busy;

    logic        b_if_req, b_if_done, b_ls_done, b_sclk, b_mosi, b_miso, b_cs1_n, b_cs2_n, b_busy;
    logic [23:0] b_if_addr;
    logic [31:0] b_if_rdata, b_ls_rdata;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    exp_t        sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_bus_arbiter #(.SCLK_HALF(1), .ADDR_W(24)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .ls_req(ls_req), .ls_we(ls_we), .ls_sel(ls_sel), .ls_size(ls_size),
        .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_rdata(ls_rdata), .ls_done(ls_done),
        .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .spi_cs1_n(spi_cs1_n), .spi_cs2_n(spi_cs2_n), .busy(busy)
    );

    spi_bus_arbiter #(.SCLK_HALF(3), .ADDR_W(24)) u_dut3 (
        .clk(clk), .rst(rst),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_done(b_if_done),
        .ls_req(1'b0), .ls_we(1'b0), .ls_sel(1'b0), .ls_size(2'b00),
        .ls_addr(24'd0), .ls_wdata(32'd0), .ls_rdata(b_ls_rdata), .ls_done(b_ls_done),
        .spi_sclk(b_sclk), .spi_mosi(b_mosi), .spi_miso(b_miso),
        .spi_cs1_n(b_cs1_n), .spi_cs2_n(b_cs2_n), .busy(b_busy)
    );

    // SPI slave models: capture mosi on sclk rise, shift miso on sclk fall.
    logic [63:0] next_resp, resp, cap, b_next_resp, b_resp, b_cap;
    int          ncap, b_ncap;
    logic        s_sclk_p, s_cs_p, b_sclk_p, b_cs_p;
    logic        cs_any, b_cs_any;
    assign cs_any   = !spi_cs1_n || !spi_cs2_n;
    assign b_cs_any = !b_cs1_n || !b_cs2_n;
    assign spi_miso = resp[63];
    assign b_miso   = b_resp[63];

    always @(negedge clk) begin
        s_sclk_p <= spi_sclk;
        s_cs_p   <= cs_any;
        if (cs_any && !s_cs_p) begin
            resp <= next_resp; cap <= '0; ncap <= 0;
        end else if (cs_any && spi_sclk && !s_sclk_p) begin
            cap <= {cap[62:0], spi_mosi}; ncap <= ncap + 1;
        end else if (cs_any && !spi_sclk && s_sclk_p) begin
            resp <= {resp[62:0], 1'b0};
        end
    end

    always @(negedge clk) begin
        b_sclk_p <= b_sclk;
        b_cs_p   <= b_cs_any;
        if (b_cs_any && !b_cs_p) begin
            b_resp <= b_next_resp; b_cap <= '0; b_ncap <= 0;
        end else if (b_cs_any && b_sclk && !b_sclk_p) begin
            b_cap <= {b_cap[62:0], b_mosi}; b_ncap <= b_ncap + 1;
        end else if (b_cs_any && !b_sclk && b_sclk_p) begin
            b_resp <= {b_resp[62:0], 1'b0};
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic is_ls, input logic [63:0] frame, input int nbits,
                        input int lat, input logic cs2, input logic [31:0] rdata);
        exp_t e;
        e.is_ls = is_ls; e.frame = frame; e.nbits = nbits;
        e.lat = lat; e.cs2 = cs2; e.rdata = rdata;
        sb.push_back(e);
    endtask

    // Monitor: pops an expectation on every done pulse.
    int   t_start = 0;
    int   overlap = 0;
    logic busy_p = 1'b0, saw1 = 1'b0, saw2 = 1'b0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (busy && !busy_p) begin
                t_start = cyc; saw1 = 1'b0; saw2 = 1'b0;
            end
            busy_p = busy;
            if (!spi_cs1_n) saw1 = 1'b1;
            if (!spi_cs2_n) saw2 = 1'b1;
            if (!spi_cs1_n && !spi_cs2_n) overlap++;
            if (if_done || ls_done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", {62'd0, if_done, ls_done}, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("grant_ls", 64'(ls_done), 64'(e.is_ls));
                    chk("both_done", 64'(if_done && ls_done), 64'd0);
                    chk("latency", 64'(cyc - t_start + 1), 64'(e.lat));
                    chk("bit_count", 64'(ncap), 64'(e.nbits));
                    chk("mosi_frame", cap, e.frame);
                    chk("cs1_used", 64'(saw1), 64'(!e.cs2));
                    chk("cs2_used", 64'(saw2), 64'(e.cs2));
                    chk("rdata", 64'(e.is_ls ? ls_rdata : if_rdata), 64'(e.rdata));
                end
            end
        end
    end

    // sclk run lengths on the SCLK_HALF=3 instance.
    int   b_run = 0, hi_min = 999, hi_max = 0, lo_min = 999, lo_max = 0;
    logic b_prev = 1'b0;
    always @(negedge clk) begin
        if (!b_busy) begin
            b_run <= 0;
        end else if (b_run == 0 || b_sclk == b_prev) begin
            b_run <= b_run + 1;
        end else begin
            if (b_prev) begin
                if (b_run < hi_min) hi_min <= b_run;
                if (b_run > hi_max) hi_max <= b_run;
            end else begin
                if (b_run < lo_min) lo_min <= b_run;
                if (b_run > lo_max) lo_max <= b_run;
            end
            b_run <= 1;
        end
        b_prev <= b_sclk;
    end

    task automatic do_if(input logic [23:0] addr, input logic [63:0] r);
        bit got = 0;
        next_resp = r; if_addr = addr; if_req = 1'b1;
        for (int i = 0; i < 1000 && !got; i++) begin
            @(negedge clk);
            if (if_done) got = 1;
        end
        if_req = 1'b0;
        if (!got) chk("if_timeout", 64'd0, 64'd1);
    endtask

    task automatic do_ls(input logic we, input logic sel, input logic [1:0] size,
                         input logic [23:0] addr, input logic [31:0] wd, input logic [63:0] r);
        bit got = 0;
        next_resp = r; ls_we = we; ls_sel = sel; ls_size = size;
        ls_addr = addr; ls_wdata = wd; ls_req = 1'b1;
        for (int i = 0; i < 1000 && !got; i++) begin
            @(negedge clk);
            if (ls_done) got = 1;
        end
        ls_req = 1'b0;
        if (!got) chk("ls_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        rst = 1'b1;
        if_req = 0; ls_req = 0; ls_we = 0; ls_sel = 0; ls_size = 0;
        if_addr = 0; ls_addr = 0; ls_wdata = 0; next_resp = 0;
        b_if_req = 0; b_if_addr = 0; b_next_resp = 0;
        repeat (3) @(negedge clk);
        chk("rst_cs1_n", 64'(spi_cs1_n), 64'd1);
        chk("rst_cs2_n", 64'(spi_cs2_n), 64'd1);
        chk("rst_sclk", 64'(spi_sclk), 64'd0);
        chk("rst_mosi", 64'(spi_mosi), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", {62'd0, if_done, ls_done}, 64'd0);
        chk("rst_if_rdata", 64'(if_rdata), 64'd0);
        chk("rst_ls_rdata", 64'(ls_rdata), 64'd0);
        rst = 1'b0;

        fork
            begin : b_slow_clock
                bit got = 0;
                int c0;
                b_next_resp = {32'h0, 32'h78563412};
                b_if_addr = 24'h000400; b_if_req = 1'b1; c0 = cyc;
                for (int i = 0; i < 2000 && !got; i++) begin
                    @(negedge clk);
                    if (b_if_done) begin
                        got = 1;
                        chk("b_latency", 64'(cyc - c0), 64'd388);
                        chk("b_rdata", 64'(b_if_rdata), 64'h12345678);
                        chk("b_frame", b_cap, 64'h0300040000000000);
                        chk("b_bits", 64'(b_ncap), 64'd64);
                    end
                end
                b_if_req = 1'b0;
                if (!got) chk("b_timeout", 64'd0, 64'd1);
                chk("b_hi_min", 64'(hi_min), 64'd3);
                chk("b_hi_max", 64'(hi_max), 64'd3);
                chk("b_lo_min", 64'(lo_min), 64'd3);
                chk("b_lo_max", 64'(lo_max), 64'd3);
            end
            begin : main_seq
                push(1'b0, 64'h0300010000000000, 64, 130, 1'b0, 32'h00000513);
                do_if(24'h000100, {32'h0, 32'h13050000});
                push(1'b1, 64'h0000000300002000, 40, 82, 1'b1, 32'h000000A5);
                do_ls(1'b0, 1'b1, 2'b00, 24'h000020, 32'h0, {32'h0, 8'hA5, 24'h0});
                push(1'b1, 64'h02000010EFBEADDE, 64, 130, 1'b1, 32'h000000A5);
                do_ls(1'b1, 1'b1, 2'b10, 24'h000010, 32'hDEADBEEF, 64'h0);
                push(1'b1, 64'h0000031234560000, 48, 98, 1'b0, 32'h00001234);
                do_ls(1'b0, 1'b0, 2'b01, 24'h123456, 32'h0, {32'h0, 16'h3412, 16'h0});
                chk("if_rdata_hold", 64'(if_rdata), 64'h00000513);
            end
        join

        // Both requesters held from reset: LS, IF, LS, IF.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        next_resp = {32'h0, 32'h11223344};
        for (int k = 0; k < 2; k++) begin
            push(1'b1, 64'h0000000300000400, 40, 82, 1'b1, 32'h00000011);
            push(1'b0, 64'h0300020000000000, 64, 130, 1'b0, 32'h44332211);
        end
        ls_we = 0; ls_sel = 1; ls_size = 2'b00; ls_addr = 24'h000004; if_addr = 24'h000200;
        ls_req = 1'b1; if_req = 1'b1;
        fork
            begin
                int n = 0;
                for (int i = 0; i < 2000 && n < 2; i++) begin
                    @(negedge clk);
                    if (ls_done) n++;
                end
                ls_req = 1'b0;
                if (n < 2) chk("tie_ls_timeout", 64'(n), 64'd2);
            end
            begin
                int n = 0;
                for (int i = 0; i < 2000 && n < 2; i++) begin
                    @(negedge clk);
                    if (if_done) n++;
                end
                if_req = 1'b0;
                if (n < 2) chk("tie_if_timeout", 64'(n), 64'd2);
            end
        join
        repeat (2) @(negedge clk);

        // Reset during the address phase, then replay of the held request.
        push(1'b0, 64'h0300030000000000, 64, 130, 1'b0, 32'h0DF0FECA);
        next_resp = {32'h0, 32'hCAFEF00D};
        if_addr = 24'h000300; if_req = 1'b1;
        for (int i = 0; i < 200 && ncap < 16; i++) @(negedge clk);
        chk("mid_addr_reached", 64'(ncap >= 16), 64'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_cs1_n", 64'(spi_cs1_n), 64'd1);
        chk("rst_mid_cs2_n", 64'(spi_cs2_n), 64'd1);
        chk("rst_mid_sclk", 64'(spi_sclk), 64'd0);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        begin
            bit got = 0;
            for (int i = 0; i < 1000 && !got; i++) begin
                @(negedge clk);
                if (if_done) got = 1;
            end
            if_req = 1'b0;
            if (!got) chk("replay_timeout", 64'd0, 64'd1);
        end

        repeat (3) @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        chk("cs_overlap", 64'(overlap), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
